// File: rtl/acc_pkg.sv
// Shared encodings for the split accumulator: opcodes, FSM states and shift-op classification.
// Build option: ACC_ROTATE_EN enables ROR/ROL as real (and sequenceable) shift ops.
package acc_pkg;

  localparam logic [2:0] ACC_OP_HOLD = 3'b000;
  localparam logic [2:0] ACC_OP_LOAD = 3'b001;
  localparam logic [2:0] ACC_OP_SHR  = 3'b010;
  localparam logic [2:0] ACC_OP_SHL  = 3'b011;
  localparam logic [2:0] ACC_OP_ROR  = 3'b100;
  localparam logic [2:0] ACC_OP_ROL  = 3'b101;
  localparam logic [2:0] ACC_OP_CLR  = 3'b110;
  localparam logic [2:0] ACC_OP_RSVD = 3'b111;

  typedef enum logic {
    ACC_ST_IDLE  = 1'b0,
    ACC_ST_SHIFT = 1'b1
  } acc_state_e;

  // Rotates only count as shift ops when the rotate feature is built in.
  function automatic logic is_shift_op(input logic [2:0] op);
`ifdef ACC_ROTATE_EN
    return (op == ACC_OP_SHR) || (op == ACC_OP_SHL) ||
           (op == ACC_OP_ROR) || (op == ACC_OP_ROL);
`else
    return (op == ACC_OP_SHR) || (op == ACC_OP_SHL);
`endif
  endfunction

endpackage

// File: rtl/acc_half_reg.sv
// One half of the accumulator: synchronously cleared register with a tri-state bus view.
module acc_half_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_p,
  input  logic         rd_en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] data2bus
);

  always_ff @(posedge clk) begin
    if (reset_p) q <= '0;
    else         q <= d;
  end

  assign data2bus = rd_en ? q : 'z;

endmodule

// File: rtl/acc_nbit_seq.sv
// 2*HALF_W-bit split accumulator with single-step ops and a sequenced multi-bit shift.
// Build option: ACC_ROTATE_EN enables ROR/ROL (otherwise they behave as HOLD).
module acc_nbit_seq
  import acc_pkg::*;
#(
  parameter int HALF_W  = 4,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               reset_p,
  input  logic               acc_high_reset_p,
  input  logic               rd_en,
  input  logic               acc_in_select,
  input  logic [2:0]         op,
  input  logic               start,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               fill_value,
  input  logic [HALF_W-1:0]  bus_data,
  input  logic [HALF_W-1:0]  alu_data,
  output logic [HALF_W-1:0]  acc_high_data2bus,
  output logic [HALF_W-1:0]  acc_low_data2bus,
  output logic [HALF_W-1:0]  acc_high_register_data,
  output logic [HALF_W-1:0]  acc_low_register_data,
  output logic               busy,
  output logic               done
);

  localparam int FW = 2 * HALF_W;

  acc_state_e         state_reg, state_next;
  logic [SHAMT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]         op_reg, op_next;
  logic               fill_reg, fill_next;
  logic               done_reg, done_next;
  logic [FW-1:0]      word, word_next;
  logic [HALF_W-1:0]  src;

  function automatic logic [FW-1:0] shift_word(input logic [2:0] o, input logic f,
                                               input logic [FW-1:0] w);
    logic [FW-1:0] r;
    r = w;
    case (o)
      ACC_OP_SHR: r = {f, w[FW-1:1]};
      ACC_OP_SHL: r = {w[FW-2:0], f};
`ifdef ACC_ROTATE_EN
      ACC_OP_ROR: r = {w[0], w[FW-1:1]};
      ACC_OP_ROL: r = {w[FW-2:0], w[FW-1]};
`endif
      default:    r = w;
    endcase
    return r;
  endfunction

  assign word = {acc_high_register_data, acc_low_register_data};
  assign src  = acc_in_select ? bus_data : alu_data;

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_reg <= ACC_ST_IDLE;
      cnt_reg   <= '0;
      op_reg    <= ACC_OP_HOLD;
      fill_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      op_reg    <= op_next;
      fill_reg  <= fill_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    op_next    = op_reg;
    fill_next  = fill_reg;
    done_next  = 1'b0;
    word_next  = word;
    case (state_reg)
      ACC_ST_IDLE: begin
        if (start && is_shift_op(op)) begin
          op_next   = op;
          fill_next = fill_value;
          done_next = (shamt <= SHAMT_W'(1));
          if (shamt != '0) begin
            word_next = shift_word(op, fill_value, word);
            cnt_next  = shamt - SHAMT_W'(1);
            if (shamt > SHAMT_W'(1)) state_next = ACC_ST_SHIFT;
          end else begin
            cnt_next = '0;
          end
        end else begin
          case (op)
            ACC_OP_LOAD: word_next = {src, word[FW-1:HALF_W]};
            ACC_OP_CLR:  word_next = '0;
            default:     word_next = shift_word(op, fill_value, word);
          endcase
        end
      end
      ACC_ST_SHIFT: begin
        // Live control inputs are ignored here; only the latched op/fill drive the shift.
        word_next = shift_word(op_reg, fill_reg, word);
        cnt_next  = cnt_reg - SHAMT_W'(1);
        if (cnt_reg == SHAMT_W'(1)) begin
          state_next = ACC_ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = ACC_ST_IDLE;
    endcase
  end

  // High-half clear overrides only the high register; the low half still takes word_next.
  acc_half_reg #(.W(HALF_W)) u_high (
    .clk      (clk),
    .reset_p  (reset_p | acc_high_reset_p),
    .rd_en    (rd_en),
    .d        (word_next[FW-1:HALF_W]),
    .q        (acc_high_register_data),
    .data2bus (acc_high_data2bus)
  );

  acc_half_reg #(.W(HALF_W)) u_low (
    .clk      (clk),
    .reset_p  (reset_p),
    .rd_en    (rd_en),
    .d        (word_next[HALF_W-1:0]),
    .q        (acc_low_register_data),
    .data2bus (acc_low_data2bus)
  );

  assign busy = (state_reg == ACC_ST_SHIFT);
  assign done = done_reg;

endmodule

// File: tb/tb_acc_nbit_seq.sv
// Directed bench for acc_nbit_seq (HALF_W=4, SHAMT_W=3); expectations hand-computed.
module tb_acc_nbit_seq;
  import acc_pkg::*;

  logic       clk = 1'b0;
  logic       reset_p = 1'b1;
  logic       acc_high_reset_p = 1'b0;
  logic       rd_en = 1'b0;
  logic       acc_in_select = 1'b1;
  logic [2:0] op = ACC_OP_HOLD;
  logic       start = 1'b0;
  logic [2:0] shamt = 3'd0;
  logic       fill_value = 1'b0;
  logic [3:0] bus_data = 4'h0;
  logic [3:0] alu_data = 4'h0;
  wire  [3:0] hb, lb;
  logic [3:0] hq, lq;
  logic       busy, done;

  int checks = 0;
  int passes = 0;

  acc_nbit_seq #(.HALF_W(4), .SHAMT_W(3)) dut (
    .clk                    (clk),
    .reset_p                (reset_p),
    .acc_high_reset_p       (acc_high_reset_p),
    .rd_en                  (rd_en),
    .acc_in_select          (acc_in_select),
    .op                     (op),
    .start                  (start),
    .shamt                  (shamt),
    .fill_value             (fill_value),
    .bus_data               (bus_data),
    .alu_data               (alu_data),
    .acc_high_data2bus      (hb),
    .acc_low_data2bus       (lb),
    .acc_high_register_data (hq),
    .acc_low_register_data  (lq),
    .busy                   (busy),
    .done                   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) begin
      passes++;
      $display("ok   %-14s got=%0h", tag, got);
    end else begin
      $display("FAIL %-14s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [7:0] w, input logic b, input logic d);
    check({tag, ".word"}, {hq, lq}, w);
    check({tag, ".busy"}, busy, b);
    check({tag, ".done"}, done, d);
  endtask

  task automatic set_word(input logic [3:0] h, input logic [3:0] l);
    op = ACC_OP_LOAD; acc_in_select = 1'b1;
    bus_data = l; tick();
    bus_data = h; tick();
    op = ACC_OP_HOLD;
  endtask

  initial begin
    tick();
    reset_p = 1'b0;
    check_state("reset", 8'h00, 1'b0, 1'b0);

    op = ACC_OP_LOAD; acc_in_select = 1'b1; bus_data = 4'hA; tick();
    check("load_bus", {hq, lq}, 8'hA0);
    acc_in_select = 1'b0; alu_data = 4'h3; tick();
    check("load_alu", {hq, lq}, 8'h3A);

    op = ACC_OP_SHR; fill_value = 1'b1; tick();
    check("shr_fill1", {hq, lq}, 8'h9D);
    op = ACC_OP_SHL; fill_value = 1'b0; tick();
    check("shl_fill0", {hq, lq}, 8'h3A);

    // Sequenced SHR by 3 from 81; inputs scrambled while busy.
    set_word(4'h8, 4'h1);
    op = ACC_OP_SHR; start = 1'b1; shamt = 3'd3; fill_value = 1'b0; tick();
    op = ACC_OP_CLR; fill_value = 1'b1; shamt = 3'd7; bus_data = 4'h5;
    check_state("seq1", 8'h40, 1'b1, 1'b0);
    tick();
    check_state("seq2", 8'h20, 1'b1, 1'b0);
    tick();
    op = ACC_OP_HOLD; start = 1'b0;
    check_state("seq3", 8'h10, 1'b0, 1'b1);
    tick();
    check_state("seq_after", 8'h10, 1'b0, 1'b0);

    // Zero-length sequence: no shift, no busy, single done.
    op = ACC_OP_SHL; start = 1'b1; shamt = 3'd0; tick();
    op = ACC_OP_HOLD; start = 1'b0;
    check_state("k0", 8'h10, 1'b0, 1'b1);
    tick();
    check("k0_after.done", done, 1'b0);

    // Reset partway through a 7-step sequence.
    set_word(4'h8, 4'h1);
    op = ACC_OP_SHR; start = 1'b1; shamt = 3'd7; fill_value = 1'b0; tick();
    op = ACC_OP_HOLD; start = 1'b0; tick();
    check_state("mid", 8'h20, 1'b1, 1'b0);
    reset_p = 1'b1; tick();
    reset_p = 1'b0;
    check_state("mid_rst", 8'h00, 1'b0, 1'b0);
    tick();
    check_state("mid_after", 8'h00, 1'b0, 1'b0);

    // ROL by one: rotates only when the feature is built in.
    set_word(4'h8, 4'h1);
    op = ACC_OP_ROL; start = 1'b1; shamt = 3'd1; tick();
    op = ACC_OP_HOLD; start = 1'b0;
`ifdef ACC_ROTATE_EN
    check_state("rol", 8'h03, 1'b0, 1'b1);
`else
    check_state("rol", 8'h81, 1'b0, 1'b0);
`endif
    tick();

    // Bus view and high-half clear.
    set_word(4'hF, 4'hF);
    rd_en = 1'b1; #1;
    check("bus_high", hb, 4'hF);
    check("bus_low", lb, 4'hF);
    rd_en = 1'b0; #1;
    check("bus_high_off", hb === hq, 1'b0);
    check("bus_low_off", lb === lq, 1'b0);
    acc_high_reset_p = 1'b1; tick();
    acc_high_reset_p = 1'b0;
    check("high_clr", {hq, lq}, 8'h0F);

    op = ACC_OP_CLR; tick();
    op = ACC_OP_HOLD;
    check("clr", {hq, lq}, 8'h00);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
